// File: rtl/line_mem_if.sv
// Bus between the set-associative cache (master) and the line backing
// memory controller (slave). Carries one whole line per transaction.
//
// Handshake: rd_req / wr_req are levels the master raises and holds until
// it sees gnt. The slave samples addr and wr_line only in the cycle it
// accepts the request. gnt is a single-cycle completion pulse. Dropping the
// request before gnt aborts the transaction with no side effects. After gnt
// the master must lower the request in the following cycle. Otherwise the
// level is taken as a new request. busy is high while a transaction is in flight.
interface line_mem_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

  logic [ADDR_LEN-1:0] addr;
  logic                rd_req;
  logic                wr_req;
  logic [31:0]         wr_line [LINE_SIZE];
  logic [31:0]         rd_line [LINE_SIZE];
  logic                gnt;
  logic                busy;
  logic [31:0]         rd_cnt;
  logic [31:0]         wr_cnt;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  rd_line, gnt, busy, rd_cnt, wr_cnt
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output rd_line, gnt, busy, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// Line-granularity backing memory controller. It serves whole-line reads
// and writes after a fixed access latency. It counts completed reads and
// writes so that replacement policies can be compared by memory traffic.
module line_mem_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 8   // 1..255
) (
  input  logic             clk,
  input  logic             rst_n,
  line_mem_if.slave        bus,
  output logic [1:0]       state_dbg
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int NUM_LINES = 1 << ADDR_LEN;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q [LINE_SIZE];
  logic [31:0]         wdata_d [LINE_SIZE];
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         rd_line_q [LINE_SIZE];
  logic [31:0]         rd_line_d [LINE_SIZE];
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic [31:0]         mem_line [LINE_SIZE];
  logic                active_req;

  // The array holds each word XOR its power-up image. A cleared array
  // therefore reads back as word w of line L = (L << LINE_ADDR_LEN) | w,
  // with no init sequence and no dependence on reset.
  logic [31:0] mem [NUM_LINES][LINE_SIZE] = '{default: '0};

  function automatic logic [31:0] init_word(input logic [ADDR_LEN-1:0] a,
                                            input logic [LINE_ADDR_LEN-1:0] w);
    logic [31:0] v;
    v = '0;
    v[ADDR_LEN+LINE_ADDR_LEN-1:0] = {a, w};
    return v;
  endfunction

  // Decode the stored line at the latched address back to real data.
  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      mem_line[i] = mem[addr_q][i] ^ init_word(addr_q, LINE_ADDR_LEN'(i));
    end
  end

  // Next-state and datapath: accept in IDLE, count down in ACCESS, commit in DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rd_line_d  = rd_line_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    active_req = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (bus.wr_req || bus.rd_req) begin
          op_d    = bus.wr_req ? OP_WRITE : OP_READ;
          addr_d  = bus.addr;
          wdata_d = bus.wr_line;
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        active_req = (op_q == OP_WRITE) ? bus.wr_req : bus.rd_req;
        if (!active_req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (op_q == OP_WRITE) begin
          if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          rd_line_d = mem_line;
          if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '{default: '0};
      cnt_q     <= '0;
      rd_line_q <= '{default: '0};
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_line_q <= rd_line_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Line write at the edge that ends DONE. Reset never touches the array.
  always_ff @(posedge clk) begin
    if (state_q == DONE && op_q == OP_WRITE) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        mem[addr_q][i] <= wdata_q[i] ^ init_word(addr_q, LINE_ADDR_LEN'(i));
      end
    end
  end

  // In DONE the read data is presented combinationally, so it is valid in
  // the gnt cycle. After DONE the registered copy holds it.
  assign bus.rd_line = rd_line_d;
  assign bus.gnt     = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.rd_cnt  = rd_cnt_q;
  assign bus.wr_cnt  = wr_cnt_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: one LATENCY=8 instance and one LATENCY=1
// instance sharing clock and reset. A line-level model memory supplies
// expected read data through a queue that is checked at each gnt.
module tb_line_mem_ctrl;
  localparam int LW = 256;

  logic clk;
  logic rst_n;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  addr_v;
  logic [31:0] wr_line_v [8];
  logic        rd_req_v [2];
  logic        wr_req_v [2];

  line_mem_if bus8 ();
  line_mem_if bus1 ();
  logic [1:0] state_dbg8, state_dbg1;

  assign bus8.addr    = addr_v;
  assign bus8.wr_line = wr_line_v;
  assign bus8.rd_req  = rd_req_v[0];
  assign bus8.wr_req  = wr_req_v[0];
  assign bus1.addr    = addr_v;
  assign bus1.wr_line = wr_line_v;
  assign bus1.rd_req  = rd_req_v[1];
  assign bus1.wr_req  = wr_req_v[1];

  line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .state_dbg(state_dbg8)
  );
  line_mem_ctrl #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state_dbg1)
  );

  // Observed outputs, indexed by instance (0: LATENCY=8, 1: LATENCY=1).
  logic          gnt_o [2];
  logic          busy_o [2];
  logic [31:0]   rd_cnt_o [2];
  logic [31:0]   wr_cnt_o [2];
  logic [1:0]    state_o [2];
  logic [LW-1:0] rd_line_p [2];

  always_comb begin
    rd_line_p[0] = '0;
    rd_line_p[1] = '0;
    for (int i = 0; i < 8; i++) begin
      rd_line_p[0][i*32 +: 32] = bus8.rd_line[i];
      rd_line_p[1][i*32 +: 32] = bus1.rd_line[i];
    end
    gnt_o[0] = bus8.gnt;      gnt_o[1] = bus1.gnt;
    busy_o[0] = bus8.busy;    busy_o[1] = bus1.busy;
    rd_cnt_o[0] = bus8.rd_cnt; rd_cnt_o[1] = bus1.rd_cnt;
    wr_cnt_o[0] = bus8.wr_cnt; wr_cnt_o[1] = bus1.wr_cnt;
    state_o[0] = state_dbg8;  state_o[1] = state_dbg1;
  end

  // Model and scoreboard state.
  logic [LW-1:0] model_mem [2][512];
  logic [LW-1:0] last_rd [2];
  logic [31:0]   rd_model [2];
  logic [31:0]   wr_model [2];
  int            lat [2];
  int            last_gnt_cyc;
  logic [LW-1:0] exp_q [$];

  int checks;
  int failures;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + 32'(w);
    return l;
  endfunction

  // Idle-cycle checks: no grant, not busy, counters and held read data.
  task automatic idle_check(input int sel);
    check("idle_gnt", LW'(gnt_o[sel]), LW'(1'b0));
    check("idle_busy", LW'(busy_o[sel]), LW'(1'b0));
    check("idle_state", LW'(state_o[sel]), LW'(2'd0));
    check("rd_cnt", LW'(rd_cnt_o[sel]), LW'(rd_model[sel]));
    check("wr_cnt", LW'(wr_cnt_o[sel]), LW'(wr_model[sel]));
    check("rd_line_held", rd_line_p[sel], last_rd[sel]);
  endtask

  // Driver: one full transaction, with the request dropped after gnt.
  task automatic run_op(input int sel, input logic wr, input logic rd,
                        input logic [8:0] a, input logic [LW-1:0] data);
    int  k;
    bit  got;
    logic [LW-1:0] e;
    @(negedge clk);
    idle_check(sel);
    addr_v = a;
    for (int w = 0; w < 8; w++) wr_line_v[w] = data[w*32 +: 32];
    rd_req_v[sel] = rd;
    wr_req_v[sel] = wr;
    if (!wr) exp_q.push_back(model_mem[sel][a]);
    got = 1'b0;
    k = 0;
    while (!got && k < 300) begin
      @(negedge clk);
      k++;
      // Bus contents after acceptance must not matter.
      addr_v = 9'($urandom);
      for (int w = 0; w < 8; w++) wr_line_v[w] = $urandom;
      if (gnt_o[sel]) got = 1'b1;
      else check("busy_in_flight", LW'(busy_o[sel]), LW'(1'b1));
    end
    check("gnt_seen", LW'(got), LW'(1'b1));
    check("gnt_latency", LW'(k), LW'(lat[sel]));
    if (got) begin
      last_gnt_cyc = cyc;
      if (!wr) begin
        e = exp_q.pop_front();
        check("rd_line_at_gnt", rd_line_p[sel], e);
        last_rd[sel] = e;
        rd_model[sel] = rd_model[sel] + 32'd1;
      end else begin
        model_mem[sel][a] = data;
        wr_model[sel] = wr_model[sel] + 32'd1;
      end
    end
    rd_req_v[sel] = 1'b0;
    wr_req_v[sel] = 1'b0;
  endtask

  initial begin
    int prev_gnt;
    logic [8:0] ra;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    addr_v = '0;
    for (int w = 0; w < 8; w++) wr_line_v[w] = '0;
    for (int s = 0; s < 2; s++) begin
      rd_req_v[s] = 1'b0;
      wr_req_v[s] = 1'b0;
      last_rd[s] = '0;
      rd_model[s] = '0;
      wr_model[s] = '0;
      for (int l = 0; l < 512; l++)
        for (int w = 0; w < 8; w++)
          model_mem[s][l][w*32 +: 32] = (32'(l) << 3) | 32'(w);
    end
    lat[0] = 8;
    lat[1] = 1;

    // Reset state.
    repeat (2) @(negedge clk);
    idle_check(0);
    idle_check(1);
    rst_n = 1'b1;

    // Read line 5: words 0x28..0x2F.
    run_op(0, 1'b0, 1'b1, 9'd5, '0);
    check("line5_pattern", last_rd[0],
          {32'h2F, 32'h2E, 32'h2D, 32'h2C, 32'h2B, 32'h2A, 32'h29, 32'h28});

    // Write line 3 then read it back.
    run_op(0, 1'b1, 1'b0, 9'd3, make_line(32'hA0));
    run_op(0, 1'b0, 1'b1, 9'd3, '0);
    check("raw_line3", last_rd[0], make_line(32'hA0));

    // Both requests on line 7: the write wins.
    run_op(0, 1'b1, 1'b1, 9'd7, make_line(32'hFFFF_FFF0));
    run_op(0, 1'b0, 1'b1, 9'd7, '0);

    // Abort: read dropped at cycle 4, then a new read at cycle 6.
    @(negedge clk);
    idle_check(0);
    addr_v = 9'd9;
    rd_req_v[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("abort_no_gnt", LW'(gnt_o[0]), LW'(1'b0));
    end
    rd_req_v[0] = 1'b0;
    @(negedge clk);
    idle_check(0);
    run_op(0, 1'b0, 1'b1, 9'd12, '0);

    // Random traffic over lines that the reset test does not use.
    for (int n = 0; n < 6; n++) begin
      ra = 9'($urandom_range(100, 500));
      if ($urandom_range(0, 1) == 1)
        run_op(0, 1'b1, 1'b0, ra, make_line($urandom));
      else
        run_op(0, 1'b0, 1'b1, ra, '0);
    end

    // Mid-write reset: the write to line 2 is lost.
    @(negedge clk);
    idle_check(0);
    addr_v = 9'd2;
    for (int w = 0; w < 8; w++) wr_line_v[w] = 32'h11 + 32'(w);
    wr_req_v[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("pre_reset_no_gnt", LW'(gnt_o[0]), LW'(1'b0));
    end
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      rd_model[s] = '0;
      wr_model[s] = '0;
      last_rd[s] = '0;
    end
    idle_check(0);
    idle_check(1);
    wr_req_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 1'b1, 9'd2, '0);
    check("line2_after_reset", last_rd[0],
          {32'd23, 32'd22, 32'd21, 32'd20, 32'd19, 32'd18, 32'd17, 32'd16});

    // LATENCY=1: chain of four reads, one grant every two cycles.
    prev_gnt = 0;
    for (int n = 0; n < 4; n++) begin
      run_op(1, 1'b0, 1'b1, 9'(n + 20), '0);
      if (n > 0) check("lat1_gnt_spacing", LW'(last_gnt_cyc - prev_gnt), LW'(2));
      prev_gnt = last_gnt_cyc;
    end
    @(negedge clk);
    idle_check(1);
    idle_check(0);
    check("lat1_rd_cnt4", LW'(rd_cnt_o[1]), LW'(32'd4));
    check("exp_q_drained", LW'(exp_q.size()), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
